// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding, default timing and width helpers for the PLL reset/lock sequencer.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_SETTLE,
        ST_CHECK,
        ST_RUN,
        ST_FAULT
    } pll_state_t;

    localparam int DEF_RST_CYCLES    = 64;
    localparam int DEF_SETTLE_CYCLES = 4200;
    localparam int DEF_WIN_CYCLES    = 256;
    localparam int DEF_EXP_EDGES     = 64;
    localparam int DEF_TOL           = 4;
    localparam int DEF_GOOD_WINDOWS  = 2;
    localparam int DEF_MAX_RETRY     = 3;

    // Bits needed for a counter spanning 0..n-1 (never narrower than 1).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int edge_width(input int exp_edges);
        return $clog2(2 * exp_edges) + 1;
    endfunction

endpackage

// File: rtl/pll_freq_mon.sv
// Frequency monitor: synchronises the clk0-domain feedback toggle and counts its
// transitions over back-to-back refclk windows, flagging whether each window is in range.
module pll_freq_mon
    import pll_ctrl_pkg::*;
#(
    parameter int WIN_CYCLES = DEF_WIN_CYCLES,
    parameter int EXP_EDGES  = DEF_EXP_EDGES,
    parameter int TOL        = DEF_TOL
) (
    input  logic                                refclk,
    input  logic                                reset_n,
    input  logic                                clear,
    input  logic                                fb_toggle,
    output logic                                win_done,
    output logic                                in_range,
    output logic [edge_width(EXP_EDGES)-1:0]    edge_cnt
);

    localparam int EW = edge_width(EXP_EDGES);
    localparam int WW = cnt_width(WIN_CYCLES);
    localparam logic [WW-1:0] WIN_LAST = WW'(WIN_CYCLES - 1);
    localparam logic [EW-1:0] EDGE_LO  = EW'(EXP_EDGES - TOL);
    localparam logic [EW-1:0] EDGE_HI  = EW'(EXP_EDGES + TOL);

    logic [2:0]    sync_reg;
    logic [2:0]    sync_in;
    logic          edge_flag;
    logic [WW-1:0] win_cnt_reg;
    logic [EW-1:0] acc_reg;
    logic [EW-1:0] acc_next;
    logic [EW-1:0] edge_cnt_reg;
    logic          win_done_reg;
    logic          in_range_reg;

    assign sync_in = {sync_reg[1:0], fb_toggle};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            always_ff @(posedge refclk) begin
                if (!reset_n) begin
                    sync_reg[gi] <= 1'b0;
                end else begin
                    sync_reg[gi] <= sync_in[gi];
                end
            end
        end
    endgenerate

    assign edge_flag = sync_reg[1] ^ sync_reg[2];

    // Saturating accumulate so a runaway feedback clock cannot wrap into range.
    always_comb begin
        acc_next = acc_reg;
        if (edge_flag && (acc_reg != '1)) begin
            acc_next = acc_reg + EW'(1);
        end
    end

    always_ff @(posedge refclk) begin
        if (!reset_n) begin
            win_cnt_reg  <= '0;
            acc_reg      <= '0;
            edge_cnt_reg <= '0;
            win_done_reg <= 1'b0;
            in_range_reg <= 1'b0;
        end else if (clear) begin
            win_cnt_reg  <= '0;
            acc_reg      <= '0;
            win_done_reg <= 1'b0;
            in_range_reg <= 1'b0;
        end else begin
            win_done_reg <= 1'b0;
            if (win_cnt_reg == WIN_LAST) begin
                win_cnt_reg  <= '0;
                acc_reg      <= '0;
                edge_cnt_reg <= acc_next;
                in_range_reg <= (acc_next >= EDGE_LO) && (acc_next <= EDGE_HI);
                win_done_reg <= 1'b1;
            end else begin
                win_cnt_reg <= win_cnt_reg + WW'(1);
                acc_reg     <= acc_next;
            end
        end
    end

    assign win_done = win_done_reg;
    assign in_range = in_range_reg;
    assign edge_cnt = edge_cnt_reg;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset/lock sequencer: pulses pllreset, waits for settle, verifies the feedback
// frequency and only then releases the downstream system reset; retries then faults.
module pll_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int WIN_CYCLES    = DEF_WIN_CYCLES,
    parameter int EXP_EDGES     = DEF_EXP_EDGES,
    parameter int TOL           = DEF_TOL,
    parameter int GOOD_WINDOWS  = DEF_GOOD_WINDOWS,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic                                refclk,
    input  logic                                reset_n,
    input  logic                                fb_toggle,
    input  logic                                soft_req,
    output logic                                pll_rst,
    output logic                                pll_ready,
    output logic                                sys_rst_n,
    output logic                                fault,
    output logic [1:0]                          retry_cnt,
    output logic [edge_width(EXP_EDGES)-1:0]    edge_cnt
);

    localparam int PHASE_MAX = (SETTLE_CYCLES > RST_CYCLES) ? SETTLE_CYCLES : RST_CYCLES;
    localparam int PW = cnt_width(PHASE_MAX);
    localparam int GW = cnt_width(GOOD_WINDOWS);
    localparam logic [PW-1:0] RST_LAST    = PW'(RST_CYCLES - 1);
    localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
    localparam logic [GW-1:0] GOOD_LAST   = GW'(GOOD_WINDOWS - 1);
    localparam logic [1:0]    RETRY_LAST  = 2'(MAX_RETRY - 1);

    pll_state_t    state_reg;
    logic [PW-1:0] phase_cnt_reg;
    logic [GW-1:0] good_cnt_reg;
    logic [1:0]    retry_cnt_reg;
    logic          pll_rst_reg;
    logic          pll_ready_reg;
    logic          sys_rst_n_reg;
    logic          fault_reg;
    logic          mon_clear;
    logic          win_done;
    logic          in_range;

    // Measurement only runs while the PLL is supposed to be up.
    assign mon_clear = soft_req || !((state_reg == ST_CHECK) || (state_reg == ST_RUN));

    pll_freq_mon #(
        .WIN_CYCLES (WIN_CYCLES),
        .EXP_EDGES  (EXP_EDGES),
        .TOL        (TOL)
    ) u_freq_mon (
        .refclk     (refclk),
        .reset_n    (reset_n),
        .clear      (mon_clear),
        .fb_toggle  (fb_toggle),
        .win_done   (win_done),
        .in_range   (in_range),
        .edge_cnt   (edge_cnt)
    );

    always_ff @(posedge refclk) begin
        if (!reset_n || soft_req) begin
            state_reg     <= ST_ASSERT;
            phase_cnt_reg <= '0;
            good_cnt_reg  <= '0;
            retry_cnt_reg <= '0;
            pll_rst_reg   <= 1'b1;
            pll_ready_reg <= 1'b0;
            sys_rst_n_reg <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_ASSERT: begin
                    if (phase_cnt_reg == RST_LAST) begin
                        state_reg     <= ST_SETTLE;
                        phase_cnt_reg <= '0;
                        pll_rst_reg   <= 1'b0;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg + PW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (phase_cnt_reg == SETTLE_LAST) begin
                        state_reg     <= ST_CHECK;
                        phase_cnt_reg <= '0;
                        good_cnt_reg  <= '0;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg + PW'(1);
                    end
                end
                ST_CHECK: begin
                    if (win_done) begin
                        if (in_range) begin
                            if (good_cnt_reg == GOOD_LAST) begin
                                state_reg     <= ST_RUN;
                                good_cnt_reg  <= '0;
                                pll_ready_reg <= 1'b1;
                                sys_rst_n_reg <= 1'b1;
                            end else begin
                                good_cnt_reg <= good_cnt_reg + GW'(1);
                            end
                        end else if (retry_cnt_reg < RETRY_LAST) begin
                            state_reg     <= ST_ASSERT;
                            retry_cnt_reg <= retry_cnt_reg + 2'd1;
                            pll_rst_reg   <= 1'b1;
                        end else begin
                            state_reg   <= ST_FAULT;
                            pll_rst_reg <= 1'b1;
                            fault_reg   <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Loss of frequency while running is a fresh sequence, not a retry.
                    if (win_done && !in_range) begin
                        state_reg     <= ST_ASSERT;
                        retry_cnt_reg <= '0;
                        pll_rst_reg   <= 1'b1;
                        pll_ready_reg <= 1'b0;
                        sys_rst_n_reg <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    pll_rst_reg   <= 1'b1;
                    sys_rst_n_reg <= 1'b0;
                    fault_reg     <= 1'b1;
                end
                default: begin
                    state_reg     <= ST_ASSERT;
                    phase_cnt_reg <= '0;
                    pll_rst_reg   <= 1'b1;
                    pll_ready_reg <= 1'b0;
                    sys_rst_n_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst   = pll_rst_reg;
    assign pll_ready = pll_ready_reg;
    assign sys_rst_n = sys_rst_n_reg;
    assign fault     = fault_reg;
    assign retry_cnt = retry_cnt_reg;

endmodule
